multicycle_control: RTL



---
 rtl/multicycle_control_pkg.sv | 39 +++
 rtl/multicycle_control_mem_wait_timer.sv | 18 +
 rtl/multicycle_control.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared MIPS opcodes, FSM states, ALU codes and dispatch helpers
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP, JR, TRAP
  } state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;
  localparam logic [2:0] ALU_ADDI = 3'd4;
  localparam logic [2:0] ALU_ORI  = 3'd5;
  localparam logic [2:0] ALU_ANDI = 3'd6;
  localparam logic [2:0] ALU_R    = 3'd7;
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct, input logic jr_en);
    case (op)
      OP_R: return (jr_en && funct == FN_JR) ? JR : EXEC_R;
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return EXEC_I;
      OP_LW, OP_SW: return MEM_ADDR;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_J, OP_JAL: return JUMP;
      default: return TRAP;
    endcase
  endfunction
  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    return op == OP_ADDI ? ALU_ADDI : op == OP_ORI ? ALU_ORI : op == OP_ANDI ? ALU_ANDI : ALU_LUI;
  endfunction
endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags when MEM_WAIT_MAX is reached
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int W = $clog2(MEM_WAIT_MAX + 2);
  logic [W-1:0] count;
  assign expired = count == W'(MEM_WAIT_MAX);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (tick && !expired) count <= count + 1'b1;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with memory wait timeout and trap
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_WIDTH  = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter bit JR_ENABLE    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic [5:0]             funct,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic [1:0]             pc_source,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic                   mem_timeout
);
  state_t state, state_nx;
  logic waiting, expired, timeout, pc_wr, ir_wr, mem_wr, reg_wr, jal;
  logic [2:0] alu;
  assign waiting = state inside {FETCH, MEM_RD, MEM_WR};
  assign timeout = waiting && !mem_ready && expired;
  assign jal = op == OP_JAL;
  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk,
    .reset,
    .clear(!waiting || mem_ready),
    .tick(waiting && !mem_ready),
    .expired
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      illegal_op <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE && state_nx == TRAP) illegal_op <= 1'b1;
      if (timeout) mem_timeout <= 1'b1;
    end
  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:          state_nx = mem_ready ? DECODE : expired ? TRAP : FETCH;
      DECODE:         state_nx = dispatch(op, funct, JR_ENABLE);
      EXEC_R, EXEC_I: state_nx = WB_ALU;
      MEM_ADDR:       state_nx = op == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:         state_nx = mem_ready ? WB_MEM : expired ? TRAP : MEM_RD;
      MEM_WR:         state_nx = mem_ready ? FETCH : expired ? TRAP : MEM_WR;
      TRAP:           state_nx = TRAP;
      default:        state_nx = FETCH;
    endcase
  end
  always_comb begin
    pc_wr = 1'b0;
    ir_wr = 1'b0;
    mem_wr = 1'b0;
    reg_wr = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    reg_dst = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu = 3'd0;
    pc_source = 2'd0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        ir_wr = mem_ready;
        pc_wr = mem_ready;
        alu_src_b = 2'd1;
        alu = ALU_ADD;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu = ALU_ADD;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu = ALU_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu = imm_alu(op);
      end
      WB_ALU: begin
        reg_wr = 1'b1;
        reg_dst = op == OP_R ? 2'd1 : 2'd0;
        instr_done = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu = ALU_ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord = 1'b1;
      end
      MEM_WR: begin
        mem_wr = 1'b1;
        iord = 1'b1;
        instr_done = mem_ready;
      end
      WB_MEM: begin
        reg_wr = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu = ALU_SUB;
        pc_source = 2'd1;
        pc_wr = op == OP_BNE ? !zero : zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_wr = 1'b1;
        pc_source = 2'd2;
        reg_wr = jal;
        reg_dst = jal ? 2'd2 : 2'd0;
        mem_to_reg = jal ? 2'd2 : 2'd0;
        instr_done = 1'b1;
      end
      JR: begin
        pc_wr = 1'b1;
        pc_source = 2'd3;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
  assign pc_write = pc_wr && reset;
  assign ir_write = ir_wr && reset;
  assign mem_write = mem_wr && reset;
  assign reg_write = reg_wr && reset;
  assign alu_op = ALUOP_WIDTH'(alu);
endmodule
